// File: rtl/lfsr_checker_if.sv
// Receive-side word bus for the LFSR pattern checker: data beat, counter clear, lock/error status.
// Latency: none (wiring only); status fields are registered inside the checker.
// Backpressure: none; every beat with i_Data_DV high is consumed, and there is no ready.
interface lfsr_checker_if #(
  parameter int NUM_BITS     = 5,
  parameter int ERR_CNT_BITS = 16
);

  logic                    i_Data_DV;
  logic [NUM_BITS-1:0]     i_Data;
  logic                    i_Clear;
  logic                    o_Locked;
  logic                    o_Error;
  logic [ERR_CNT_BITS-1:0] o_Error_Count;

  // Stream source and status consumer side.
  modport master (
    output i_Data_DV,
    output i_Data,
    output i_Clear,
    input  o_Locked,
    input  o_Error,
    input  o_Error_Count
  );

  // Checker side.
  modport slave (
    input  i_Data_DV,
    input  i_Data,
    input  i_Clear,
    output o_Locked,
    output o_Error,
    output o_Error_Count
  );

endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the XNOR-LFSR word stream; flags mismatches, counts errors (LFSR_CHECKER_ERR_COUNT_EN).
// Latency: 1 cycle from a DV beat to o_Locked / o_Error / o_Error_Count.
// Backpressure: none; a beat is accepted on every cycle i_Data_DV is high.
module lfsr_checker #(
  parameter int NUM_BITS     = 5,
  parameter int LOCK_COUNT   = 8,
  parameter int LOSS_COUNT   = 4,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  lfsr_checker_if.slave bus
);

  // One-hot bit for register position p (positions numbered 1..32).
  function automatic logic [31:0] tap_bit(input int p);
    tap_bit = 32'h1 << (p - 1);
  endfunction

  // XNOR tap sets shared with the generator (Xilinx XAPP052 table).
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:       tap_mask = tap_bit(3)  | tap_bit(2);
      4:       tap_mask = tap_bit(4)  | tap_bit(3);
      5:       tap_mask = tap_bit(5)  | tap_bit(3);
      6:       tap_mask = tap_bit(6)  | tap_bit(5);
      7:       tap_mask = tap_bit(7)  | tap_bit(6);
      8:       tap_mask = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
      9:       tap_mask = tap_bit(9)  | tap_bit(5);
      10:      tap_mask = tap_bit(10) | tap_bit(7);
      11:      tap_mask = tap_bit(11) | tap_bit(9);
      12:      tap_mask = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      13:      tap_mask = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
      14:      tap_mask = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
      15:      tap_mask = tap_bit(15) | tap_bit(14);
      16:      tap_mask = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17:      tap_mask = tap_bit(17) | tap_bit(14);
      18:      tap_mask = tap_bit(18) | tap_bit(11);
      19:      tap_mask = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      20:      tap_mask = tap_bit(20) | tap_bit(17);
      21:      tap_mask = tap_bit(21) | tap_bit(19);
      22:      tap_mask = tap_bit(22) | tap_bit(21);
      23:      tap_mask = tap_bit(23) | tap_bit(18);
      24:      tap_mask = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25:      tap_mask = tap_bit(25) | tap_bit(22);
      26:      tap_mask = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      27:      tap_mask = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
      28:      tap_mask = tap_bit(28) | tap_bit(25);
      29:      tap_mask = tap_bit(29) | tap_bit(27);
      30:      tap_mask = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      31:      tap_mask = tap_bit(31) | tap_bit(28);
      32:      tap_mask = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
      default: tap_mask = 32'h0;
    endcase
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

  // Counter widths hold 0..COUNT; the "last" constants mark the beat that
  // completes the run, so the transition happens on that same beat.
  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int LW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);

  // Generator step: shift toward the MSB and insert the XNOR of the taps.
  // The tap sets all have an even number of taps, so a chained XNOR equals
  // the inverted parity of the tapped bits.
  function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] w);
    lfsr_next = {w[NUM_BITS-2:0], ~(^(w & TAPS))};
  endfunction

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              r_State;
  logic [NUM_BITS-1:0] r_Prev;
  logic                r_Prev_Vld;
  logic [NUM_BITS-1:0] r_Ref;
  logic [MW-1:0]       r_Match_Cnt;
  logic [LW-1:0]       r_Miss_Cnt;
  logic                r_Locked;
  logic                r_Error;

  state_t              w_State_Nxt;
  logic [NUM_BITS-1:0] w_Prev_Nxt;
  logic                w_Prev_Vld_Nxt;
  logic [NUM_BITS-1:0] w_Ref_Nxt;
  logic [MW-1:0]       w_Match_Nxt;
  logic [LW-1:0]       w_Miss_Nxt;
  logic                w_Error_Nxt;

  logic [NUM_BITS-1:0] w_Pred_Prev;
  logic [NUM_BITS-1:0] w_Pred_Ref;
  logic                w_Lockup_Word;
  logic                w_Search_Match;

  assign w_Pred_Prev    = lfsr_next(r_Prev);
  assign w_Pred_Ref     = lfsr_next(r_Ref);
  // All-ones maps to itself under XNOR feedback, so a stuck-high input would
  // otherwise look like a perfect stream.
  assign w_Lockup_Word  = &bus.i_Data;
  assign w_Search_Match = r_Prev_Vld && !w_Lockup_Word && (bus.i_Data == w_Pred_Prev);

  // Next-state and next-output decode for the SEARCH/LOCKED machine.
  always_comb begin
    w_State_Nxt    = r_State;
    w_Prev_Nxt     = r_Prev;
    w_Prev_Vld_Nxt = r_Prev_Vld;
    w_Ref_Nxt      = r_Ref;
    w_Match_Nxt    = r_Match_Cnt;
    w_Miss_Nxt     = r_Miss_Cnt;
    w_Error_Nxt    = 1'b0;

    case (r_State)
      SEARCH: begin
        if (bus.i_Data_DV) begin
          // Every beat becomes the next compare base; the first beat after
          // reset or loss only loads it.
          w_Prev_Nxt     = bus.i_Data;
          w_Prev_Vld_Nxt = 1'b1;
          if (r_Prev_Vld) begin
            if (w_Search_Match) begin
              if (r_Match_Cnt == LOCK_LAST) begin
                w_State_Nxt = LOCKED;
                w_Ref_Nxt   = bus.i_Data;
                w_Match_Nxt = '0;
                w_Miss_Nxt  = '0;
              end else begin
                w_Match_Nxt = r_Match_Cnt + MW'(1);
              end
            end else begin
              w_Match_Nxt = '0;
            end
          end
        end
      end

      LOCKED: begin
        if (bus.i_Data_DV) begin
          // Flywheel: the reference advances on its own prediction, so a
          // corrupted word never propagates into later comparisons.
          w_Ref_Nxt = w_Pred_Ref;
          if (bus.i_Data != w_Pred_Ref) begin
            w_Error_Nxt = 1'b1;
            if (r_Miss_Cnt == LOSS_LAST) begin
              w_State_Nxt    = SEARCH;
              w_Miss_Nxt     = '0;
              w_Match_Nxt    = '0;
              w_Prev_Nxt     = bus.i_Data;
              w_Prev_Vld_Nxt = 1'b1;
            end else begin
              w_Miss_Nxt = r_Miss_Cnt + LW'(1);
            end
          end else begin
            w_Miss_Nxt = '0;
          end
        end
      end

      default: begin
        w_State_Nxt = SEARCH;
      end
    endcase
  end

  // State, tracking registers and registered status outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State     <= SEARCH;
      r_Prev      <= '0;
      r_Prev_Vld  <= 1'b0;
      r_Ref       <= '0;
      r_Match_Cnt <= '0;
      r_Miss_Cnt  <= '0;
      r_Locked    <= 1'b0;
      r_Error     <= 1'b0;
    end else begin
      r_State     <= w_State_Nxt;
      r_Prev      <= w_Prev_Nxt;
      r_Prev_Vld  <= w_Prev_Vld_Nxt;
      r_Ref       <= w_Ref_Nxt;
      r_Match_Cnt <= w_Match_Nxt;
      r_Miss_Cnt  <= w_Miss_Nxt;
      r_Locked    <= (w_State_Nxt == LOCKED);
      r_Error     <= w_Error_Nxt;
    end
  end

  assign bus.o_Locked = r_Locked;
  assign bus.o_Error  = r_Error;

`ifdef LFSR_CHECKER_ERR_COUNT_EN
  logic [ERR_CNT_BITS-1:0] r_Err_Cnt;

  // Saturating mismatch counter; clear wins over a coincident error.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Err_Cnt <= '0;
    end else if (bus.i_Clear) begin
      r_Err_Cnt <= '0;
    end else if (w_Error_Nxt && !(&r_Err_Cnt)) begin
      r_Err_Cnt <= r_Err_Cnt + ERR_CNT_BITS'(1);
    end
  end

  assign bus.o_Error_Count = r_Err_Cnt;
`else
  // Counter not built: status reads zero and the clear input has no effect.
  logic w_unused_clear;
  assign w_unused_clear    = bus.i_Clear;
  assign bus.o_Error_Count = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboarded bench for lfsr_checker: driver pushes per-cycle expectations, monitor pops and compares.
// Latency: expectations describe outputs one clock edge after each driven cycle.
// Backpressure: none; the checker accepts every beat.
module tb_lfsr_checker;

  localparam int NB       = 5;
  localparam int CB       = 16;
  localparam int LOCK_N   = 8;
  localparam int LOSS_N   = 4;
  localparam int CNT_MAX  = 65535;

  typedef struct packed {
    logic          locked;
    logic          error;
    logic [CB-1:0] count;
  } exp_t;

  logic r_Clk;
  logic r_Rst_L;
  int   checks;
  int   failures;
  int   cyc;
  exp_t exp_q[$];

  lfsr_checker_if #(.NUM_BITS(NB), .ERR_CNT_BITS(CB)) bus ();

  lfsr_checker #(
    .NUM_BITS    (NB),
    .LOCK_COUNT  (LOCK_N),
    .LOSS_COUNT  (LOSS_N),
    .ERR_CNT_BITS(CB)
  ) dut (
    .i_Clk   (r_Clk),
    .i_Rst_L (r_Rst_L),
    .bus     (bus)
  );

  initial r_Clk = 1'b0;
  always #5 r_Clk = ~r_Clk;

  // ---------------- reference model (behavioural) ----------------
  bit m_locked;
  int m_hist[$];   // recent received words while searching
  int m_miss[$];   // recent match(0)/miss(1) history while locked
  int m_ref;
  int m_count;
  int gen;         // clean-stream generator state

  // Generator step for 5 bits: shift left, feed in (bit5 == bit3).
  function automatic int nxt5(input int w);
    int fb;
    fb = (((w >> 4) & 1) == ((w >> 2) & 1)) ? 1 : 0;
    return ((w << 1) & 31) | fb;
  endfunction

  // True when every word in the window follows its predecessor and none is all-ones.
  function automatic bit chain_ok(input int h[$]);
    for (int i = 1; i < h.size(); i++)
      if (h[i] == 31 || h[i] != nxt5(h[i-1])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_miss(input int h[$]);
    for (int i = 0; i < h.size(); i++)
      if (h[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_hist.delete();
    m_miss.delete();
    m_ref   = 0;
    m_count = 0;
  endtask

  task automatic model_step(input bit dv, input int d, input bit clr, output bit err);
    int e;
    err = 1'b0;
    if (dv) begin
      if (!m_locked) begin
        m_hist.push_back(d);
        if (m_hist.size() > LOCK_N + 1) void'(m_hist.pop_front());
        if (m_hist.size() == LOCK_N + 1 && chain_ok(m_hist)) begin
          m_locked = 1'b1;
          m_ref    = d;
          m_hist.delete();
          m_miss.delete();
        end
      end else begin
        e     = nxt5(m_ref);
        m_ref = e;
        err   = (d != e);
        m_miss.push_back(err ? 1 : 0);
        if (m_miss.size() > LOSS_N) void'(m_miss.pop_front());
        if (m_miss.size() == LOSS_N && all_miss(m_miss)) begin
          m_locked = 1'b0;
          m_miss.delete();
          m_hist.delete();
          m_hist.push_back(d);
        end
      end
    end
    if (clr) m_count = 0;
    else if (err && m_count < CNT_MAX) m_count = m_count + 1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit dv, input int d, input bit clr, input bit rst);
    exp_t e;
    bit   err;
    @(negedge r_Clk);
    bus.i_Data_DV = dv;
    bus.i_Data    = d[NB-1:0];
    bus.i_Clear   = clr;
    if (rst) begin
      if (r_Rst_L) begin
        r_Rst_L = 1'b0;
        #1;
        checks++;
        if (bus.o_Locked !== 1'b0 || bus.o_Error !== 1'b0 || bus.o_Error_Count !== '0) begin
          failures++;
          $display("FAIL async_reset cyc=%0d got locked=%0b error=%0b count=%0d want all zero",
                   cyc, bus.o_Locked, bus.o_Error, bus.o_Error_Count);
        end
      end
      r_Rst_L = 1'b0;
      model_reset();
      err = 1'b0;
    end else begin
      r_Rst_L = 1'b1;
      model_step(dv, d, clr, err);
    end
    e.locked = m_locked;
    e.error  = err;
`ifdef LFSR_CHECKER_ERR_COUNT_EN
    e.count  = m_count[CB-1:0];
`else
    e.count  = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b1);
    gen = 0;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, gen, 1'b0, 1'b0);
      gen = nxt5(gen);
    end
  endtask

  task automatic bad(input int flip, input bit clr);
    drive(1'b1, gen ^ flip, clr, 1'b0);
    gen = nxt5(gen);
  endtask

  task automatic idle(input bit clr);
    drive(1'b0, int'($urandom_range(0, 31)), clr, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge r_Clk);
      cyc++;
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.o_Locked !== e.locked || bus.o_Error !== e.error || bus.o_Error_Count !== e.count) begin
          failures++;
          $display("FAIL scoreboard cyc=%0d locked got %0b want %0b, error got %0b want %0b, count got %0d want %0d",
                   cyc, bus.o_Locked, e.locked, bus.o_Error, e.error, bus.o_Error_Count, e.count);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    r_Rst_L       = 1'b0;
    bus.i_Data_DV = 1'b0;
    bus.i_Data    = '0;
    bus.i_Clear   = 1'b0;
    model_reset();

    // Acquire lock on a clean stream from 00000, then single bit-0 error.
    do_reset(2);
    clean(12);
    bad(1, 1'b0);
    clean(6);

    // Four consecutive corrupted words drop lock, clean stream relocks.
    for (int i = 0; i < 4; i++) bad(int'($urandom_range(1, 31)), 1'b0);
    clean(14);

    // Stuck inputs never lock.
    do_reset(1);
    for (int i = 0; i < 20; i++) drive(1'b1, 31, 1'b0, 1'b0);
    do_reset(1);
    for (int i = 0; i < 20; i++) drive(1'b1, 0, 1'b0, 1'b0);

    // DV every other cycle, then error with coincident clear, then one more error.
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      clean(1);
      idle(1'b0);
    end
    bad(2, 1'b0);
    bad(4, 1'b1);
    clean(3);
    bad(1, 1'b0);
    clean(2);
    idle(1'b1);
    bad(8, 1'b0);
    clean(2);

    // Reset while locked, then relock.
    do_reset(1);
    clean(12);

    // Randomised traffic: gaps, corruption, lock-up words, clears, resets.
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        do_reset(int'($urandom_range(1, 2)));
      end else if (r < 250) begin
        idle($urandom_range(0, 19) == 0);
      end else begin
        int w;
        w = gen;
        if ($urandom_range(0, 15) == 0) w = gen ^ int'($urandom_range(1, 31));
        else if ($urandom_range(0, 99) == 0) w = 31;
        drive(1'b1, w, $urandom_range(0, 29) == 0, 1'b0);
        gen = nxt5(gen);
      end
    end

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge r_Clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
